// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: sequential instruction fetch front end.
// Issues reads to a 1-cycle-latency synchronous memory port, buffers the
// returned words with their PCs in a DEPTH-entry FIFO and presents the
// oldest entry through a valid/ready handshake. A redirect flushes the
// FIFO, discards the in-flight response and restarts fetch at a new PC.
// Optional build macro FETCH_PERF_EN adds saturating 16-bit issue and
// redirect counters (fetch_count, flush_count).
module fetch_queue_unit #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 10,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      halt,
  input  logic                      redirect,
  input  logic [ADDR_W-1:0]         redirect_addr,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      instr_valid,
  output logic [DATA_W-1:0]         instr,
  output logic [ADDR_W-1:0]         instr_pc,
  input  logic                      instr_ready,
  output logic [$clog2(DEPTH):0]    occupancy
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]               fetch_count,
  output logic [15:0]               flush_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic [OCC_W:0]    demand;
  logic              room;
  logic              issue;
  logic              push;
  logic              pop;

  // Space is reserved for the read in flight, so a push can never overflow.
  assign demand = {1'b0, count_q} + {{OCC_W{1'b0}}, inflight_q};
  assign room   = demand < (OCC_W + 1)'(DEPTH);

  // Next-state logic: redirect flushes everything, otherwise issue/push/pop.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    issue      = !reset && !redirect && !halt && room;
    push       = inflight_q && !redirect;
    pop        = (count_q != '0) && instr_ready && !redirect;
    // NOTE: blocking assignments here; this block models wires, not storage.
    pc_d       = pc_q;
    inflight_d = issue;
    tag_d      = tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (redirect) begin
      pc_d     = redirect_addr;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d  = pc_q + ADDR_W'(1);
        tag_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage write; returned word is tagged with the PC it was fetched from.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q qualifies every read, so stale words are never seen.
    if (push) begin
      data_mem[wr_ptr_q] <= mem_rdata;
      pc_mem[wr_ptr_q]   <= tag_q;
    end
  end

  assign mem_rd_en   = issue;
  assign mem_addr    = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? data_mem[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q]   : '0;
  assign occupancy   = count_q;

`ifdef FETCH_PERF_EN
  // Saturating issue and redirect counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (issue && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
      if (redirect && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed scenarios followed by random stimulus,
// all outputs compared each cycle against a queue-based reference model.
module tb_fetch_queue_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset, halt, redirect, instr_ready;
  logic [ADDR_W-1:0] redirect_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [2:0]        occupancy;
`ifdef FETCH_PERF_EN
  logic [15:0]       fetch_count, flush_count;
`endif

  fetch_queue_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .halt(halt), .redirect(redirect),
    .redirect_addr(redirect_addr), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .occupancy(occupancy)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous memory: word = A000 + address, one cycle after the strobe.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= 16'hA000 + 16'(mem_addr);

  // Reference model: a queue of delivered {pc, word} pairs plus the fetch PC.
  typedef struct { logic [ADDR_W-1:0] pc; logic [DATA_W-1:0] d; } ent_t;
  ent_t              mq[$];
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_tag;
  bit                m_infl;
  int                m_fc, m_flc;

  int  total = 0;
  int  bad   = 0;
  bit  s_valid;
  logic [ADDR_W-1:0] s_pc;
  logic [2:0]        s_occ;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance the model at posedge.
  task automatic cycle(input bit r, input bit h, input bit rd, input logic [ADDR_W-1:0] ra,
                       input bit rdy, input bit chk = 1'b1);
    bit e_issue;
    reset = r; halt = h; redirect = rd; redirect_addr = ra; instr_ready = rdy;
    e_issue = !r && !rd && !h && ((mq.size() + int'(m_infl)) < DEPTH);
    @(negedge clk);
    s_valid = instr_valid;
    s_pc    = instr_pc;
    s_occ   = occupancy;
    if (chk) begin
      check("rd_en", 32'(mem_rd_en), 32'(e_issue));
      check("addr",  32'(mem_addr),  32'(m_pc));
      check("valid", 32'(instr_valid), 32'(mq.size() != 0));
      check("occ",   32'(occupancy), 32'(mq.size()));
      if (mq.size() != 0) begin
        check("instr", 32'(instr),    32'(mq[0].d));
        check("pc",    32'(instr_pc), 32'(mq[0].pc));
      end else begin
        check("instr0", 32'(instr),    32'd0);
        check("pc0",    32'(instr_pc), 32'd0);
      end
`ifdef FETCH_PERF_EN
      check("fetch_cnt", 32'(fetch_count), 32'(m_fc));
      check("flush_cnt", 32'(flush_count), 32'(m_flc));
`endif
    end
    @(posedge clk);
    if (r) begin
      m_pc = '0; mq.delete(); m_infl = 1'b0; m_fc = 0; m_flc = 0;
    end else if (rd) begin
      mq.delete(); m_infl = 1'b0; m_pc = ra;
      if (m_flc < 16'hFFFF) m_flc++;
    end else begin
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (m_infl) mq.push_back('{m_tag, 16'hA000 + 16'(m_tag)});
      m_infl = e_issue;
      if (e_issue) begin
        m_tag = m_pc;
        m_pc  = m_pc + 10'd1;
        if (m_fc < 16'hFFFF) m_fc++;
      end
    end
    #1;
  endtask

  initial begin
    int first;
    int n;
    logic [ADDR_W-1:0] seen[$];

    reset = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
    m_pc = '0; m_tag = '0; m_infl = 1'b0; m_fc = 0; m_flc = 0;
    cycle(1, 0, 0, '0, 0, 0);
    cycle(1, 0, 0, '0, 0);

    // Cold start latency and first sequence.
    first = -1;
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, '0, 1);
      if (s_valid && first < 0) first = i;
      if (s_valid) seen.push_back(s_pc);
    end
    check("reset_latency", 32'(first), 32'd3);
    check("first_pc3", 32'(seen[3]), 32'd3);

    // Back-pressure: FIFO fills to DEPTH, then drains.
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, '0, 0);
    check("full_occ", 32'(s_occ), 32'(DEPTH));
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, '0, 1);

    // Redirect with three entries buffered and a read in flight.
    cycle(1, 0, 0, '0, 0);
    n = 0;
    while (!(mq.size() == 3 && m_infl) && n < 20) begin
      cycle(0, 0, 0, '0, 0);
      n++;
    end
    check("setup_occ3", 32'(mq.size() == 3 && m_infl), 32'd1);
    cycle(0, 0, 1, 10'h200, 1);
    first = -1;
    for (int i = 1; i <= 6; i++) begin
      cycle(0, 0, 0, '0, 1);
      if (i == 1) check("redir_occ0", 32'(s_occ), 32'd0);
      if (s_valid && first < 0) begin
        first = i;
        check("redir_pc", 32'(s_pc), 32'h200);
      end
    end
    check("redir_latency", 32'(first), 32'd3);

    // PC wrap-around.
    cycle(0, 0, 1, 10'h3FE, 1);
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, '0, 1);
      if (s_valid) seen.push_back(s_pc);
    end
    check("wrap_pc2", 32'(seen[2]), 32'h000);
    check("wrap_pc3", 32'(seen[3]), 32'h001);

    // Halt mid-stream.
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, '0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, '0, 1);

    // Reset with two entries held.
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, '0, 0);
    check("pre_reset_occ", 32'(s_occ), 32'd2);
    cycle(1, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    check("post_reset_occ", 32'(s_occ), 32'd0);

    // Redirect with halt, then back-to-back redirects.
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, 1);
    cycle(0, 1, 1, 10'h155, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, '0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 1, 10'h010, 1);
    cycle(0, 0, 1, 10'h020, 0);
    cycle(0, 0, 1, 10'h030, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, '0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, 10'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
